mem_datapath: RTL
=================

# mem_datapath

Instruction-executing memory datapath that sits directly downstream of the evolution controller. It accepts one instruction per start handshake, performs a read, write or read-modify-write against an internal world-state RAM holding food/poison coordinates and scores, and returns a result with a finished flag. A second, read-only port serves the display/sensor logic concurrently.

## Interface
- DATA_WIDTH, 16, operand/result/memory word width
- ADDR_WIDTH, 8, memory address width; RAM depth 2^ADDR_WIDTH
- OPCODE_WIDTH, 4, opcode field width
- INSTRUCTION_WIDTH, DATA_WIDTH+ADDR_WIDTH+OPCODE_WIDTH, derived; not overridden independently

Ports:
- clock  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  request; only its rising edge is acted on
- instruction  in  INSTRUCTION_WIDTH  {operand, addr, opcode}, opcode in LSBs
- finished  out  1  high when idle and result valid
- result  out  DATA_WIDTH  result of the last completed instruction
- illegal  out  1  one-cycle pulse when an unknown opcode completes
- rd_addr  in  ADDR_WIDTH  display read address
- rd_data  out  DATA_WIDTH  mem[rd_addr], one-cycle latency

## Operation
- Opcodes: 0 NOP (result 0, no write); 1 MEMREAD (result = mem[addr]); 2 MEMWRITE (mem[addr] = operand, result = operand); 3 MEMADD (mem[addr] = mem[addr] + operand mod 2^DATA_WIDTH, result = new value); 4 MEMCLR (mem[addr] = 0, result = old value); others: result 0, no write, illegal pulses.
- States: IDLE, RD, EX.
- IDLE: finished = 1. If start = 1 and start_q = 0, where start_q is start registered one cycle, then latch instruction, clear finished, and go to RD.
- RD: present the latched addr to the RAM read port, then go to EX.
- EX: RAM output is valid. Compute the result, perform the write if the opcode requires one, register result, set finished = 1, pulse illegal if needed, and go to IDLE.
- All opcodes take identical latency. NOP and illegal opcodes still pass through RD and EX.
- The latched instruction is used throughout. Changes on the instruction input after acceptance are ignored.
- Display port: rd_data is registered from mem[rd_addr] every cycle, independent of the FSM.
- Read-during-write on the display port, same address same cycle: rd_data returns the old data.
- RAM contents are not reset. Contents are undefined until written.

## Timing
- Reset values: finished = 1, result = 0, illegal = 0, state = IDLE, start_q = 0. rd_data is undefined until the first clock after reset.
- Latency, with edge E being the edge at which the start rising edge is sampled:
  - finished reads 0 after E.
  - finished = 1 and result valid after E+2.
  - The write is committed at E+2, so a following MEMREAD observes it.
- Controller compatibility: start is held high for two cycles, then low while waiting. Because finished drops at E, the controller's first wait-state sample sees 0.
- A start held high is not re-accepted. A new rising edge is required.
- A start rising edge sampled in RD or EX is ignored and lost. start_q still tracks the input, so a level that stays high is not later seen as a rising edge.
- Reset asserted mid-instruction: the FSM returns to IDLE with finished = 1 and result = 0 on the next edge. A write pending in EX at that same edge is not performed.
- MEMADD overflow wraps silently, e.g. 0xFFFF + 0x0002 = 0x0001. There is no carry flag.
- The illegal pulse is exactly one cycle, coincident with the finished rising edge.

## Test plan
- Reset: hold resetn = 0 for 2 cycles -> finished = 1, result = 0, illegal = 0.
- Write then read, two handshakes: MEMWRITE addr 0x05 operand 0x1234, then MEMREAD addr 0x05 -> each handshake:
  - finished = 0 one cycle after the start edge is sampled, back to 1 two cycles later;
  - result = 0x1234 for both instructions.
- Read-modify-write with wrap: write 0xFFFF to 0x10, then MEMADD 0x10 operand 0x0002 -> result 0x0001; a subsequent MEMREAD 0x10 returns 0x0001. Then MEMCLR 0x10 -> result 0x0001; MEMREAD 0x10 returns 0x0000.
- Handshake robustness:
  - start held high for 10 cycles -> exactly one execution;
  - second start pulse issued in RD -> ignored; memory is written once only (check with MEMADD operand 1 from 0: result 1).
- Illegal opcode 0xF at addr 0x05 -> result 0, illegal high for exactly 1 cycle, mem[0x05] unchanged (MEMREAD returns 0x1234).
- Display port: rd_addr = 0x05 during a MEMWRITE of 0xBEEF to 0x05 -> rd_data shows the old value in the write cycle and 0xBEEF the cycle after. Reset asserted during EX of a MEMWRITE to 0x20 -> finished = 1, result = 0, no write to 0x20.

Source files
------------

// File: rtl/mem_datapath.sv
// mem_datapath: one-instruction-at-a-time memory datapath over a world-state RAM.
// Each start rising edge runs one instruction through IDLE -> RD -> EX.
// A second, read-only port feeds the display/sensor logic every cycle.
module mem_datapath #(
  parameter int  DATA_WIDTH        = 16,
  parameter int  ADDR_WIDTH        = 8,
  parameter int  OPCODE_WIDTH      = 4,
  localparam int INSTRUCTION_WIDTH = DATA_WIDTH + ADDR_WIDTH + OPCODE_WIDTH
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         finished,
  output logic [DATA_WIDTH-1:0]        result,
  output logic                         illegal,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_READ  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_WRITE = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_CLR   = OPCODE_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EX   = 2'd2
  } state_t;

  state_t                         state_reg, state_next;
  logic                           start_q_reg;
  logic [INSTRUCTION_WIDTH-1:0]   instr_reg, instr_next;
  logic                           finished_reg, finished_next;
  logic [DATA_WIDTH-1:0]          result_reg, result_next;
  logic                           illegal_reg, illegal_next;

  // World-state RAM; contents are deliberately not reset
  logic [DATA_WIDTH-1:0]          mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0]          ram_q_reg;
  logic [DATA_WIDTH-1:0]          rd_data_reg;
  logic                           mem_we;
  logic [DATA_WIDTH-1:0]          mem_wdata;

  // Fields of the latched instruction: {operand, addr, opcode}
  logic [OPCODE_WIDTH-1:0]        op_f;
  logic [ADDR_WIDTH-1:0]          addr_f;
  logic [DATA_WIDTH-1:0]          operand_f;
  logic [DATA_WIDTH-1:0]          sum;

  assign op_f      = instr_reg[OPCODE_WIDTH-1:0];
  assign addr_f    = instr_reg[OPCODE_WIDTH +: ADDR_WIDTH];
  assign operand_f = instr_reg[OPCODE_WIDTH+ADDR_WIDTH +: DATA_WIDTH];
  assign sum       = ram_q_reg + operand_f;  // wraps silently, no carry kept

  // Next-state, result and write-port decode
  always_comb begin
    state_next    = state_reg;
    instr_next    = instr_reg;
    finished_next = finished_reg;
    result_next   = result_reg;
    illegal_next  = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    case (state_reg)
      IDLE: begin
        // Only a fresh rising edge is accepted; a held level is not
        if (start && !start_q_reg) begin
          instr_next    = instruction;
          finished_next = 1'b0;
          state_next    = RD;
        end
      end
      RD: begin
        // RAM read of addr_f is in flight; data is valid in EX
        state_next = EX;
      end
      EX: begin
        finished_next = 1'b1;
        state_next    = IDLE;
        case (op_f)
          OP_NOP: begin
            result_next = '0;
          end
          OP_READ: begin
            result_next = ram_q_reg;
          end
          OP_WRITE: begin
            mem_we      = 1'b1;
            mem_wdata   = operand_f;
            result_next = operand_f;
          end
          OP_ADD: begin
            mem_we      = 1'b1;
            mem_wdata   = sum;
            result_next = sum;
          end
          OP_CLR: begin
            mem_we      = 1'b1;
            mem_wdata   = '0;
            result_next = ram_q_reg;
          end
          default: begin
            result_next  = '0;
            illegal_next = 1'b1;
          end
        endcase
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM and status registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      start_q_reg  <= 1'b0;
      instr_reg    <= '0;
      finished_reg <= 1'b1;
      result_reg   <= '0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      start_q_reg  <= start;
      instr_reg    <= instr_next;
      finished_reg <= finished_next;
      result_reg   <= result_next;
      illegal_reg  <= illegal_next;
    end
  end

  // Execution port: registered read, write suppressed while reset is asserted
  always_ff @(posedge clock) begin
    if (mem_we && resetn) begin
      mem[addr_f] <= mem_wdata;
    end
    ram_q_reg <= mem[addr_f];
  end

  // Display port: registered read every cycle, old data on a same-cycle write
  always_ff @(posedge clock) begin
    rd_data_reg <= mem[rd_addr];
  end

  assign finished = finished_reg;
  assign result   = result_reg;
  assign illegal  = illegal_reg;
  assign rd_data  = rd_data_reg;

endmodule
